// File: rtl/writeback_arbiter.sv
// Register-file writeback arbiter: merges the single-cycle ALU result with a FIFO of
// long-latency results onto one write port. A starvation guard forces the FIFO to win.
module writeback_arbiter #(
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          alu_valid,
  output logic                          alu_ready,
  input  logic [4:0]                    alu_rd,
  input  logic [31:0]                   alu_data,
  input  logic                          alu_is_fp,
  input  logic                          ll_valid,
  output logic                          ll_ready,
  input  logic [4:0]                    ll_rd,
  input  logic [31:0]                   ll_data,
  input  logic                          ll_is_fp,
  output logic                          wb_write_enable,
  output logic [4:0]                    wb_write_addr,
  output logic [31:0]                   wb_write_data,
  output logic                          wb_is_fp,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          wb_busy
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [SW-1:0] LIMIT_C = SW'(STARVE_LIMIT);

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        is_fp;
  } wb_entry_t;

  wb_entry_t       mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [SW-1:0]   starve_cnt;
  logic            fifo_ne, force_fifo, push, pop, grant_alu, grant;
  wb_entry_t       alu_e, ll_e, head_e, sel_e;

  assign alu_e  = '{rd: alu_rd, data: alu_data, is_fp: alu_is_fp};
  assign ll_e   = '{rd: ll_rd,  data: ll_data,  is_fp: ll_is_fp};
  assign head_e = mem[rd_ptr];

  // Candidacy uses the registered count, so a same-cycle push is never granted.
  assign fifo_ne    = (fifo_count != '0);
  assign ll_ready   = (fifo_count < DEPTH_C);
  assign force_fifo = (starve_cnt == LIMIT_C) && fifo_ne;
  assign alu_ready  = !force_fifo;
  assign grant_alu  = alu_valid && !force_fifo;
  assign pop        = force_fifo || (fifo_ne && !alu_valid);
  assign grant      = pop || grant_alu;
  assign push       = ll_valid && ll_ready;
  assign sel_e      = pop ? head_e : alu_e;

  assign wb_busy = fifo_ne || wb_write_enable;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= ll_e;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (!fifo_ne || pop) begin
      starve_cnt <= '0;
    end else if (starve_cnt != LIMIT_C) begin
      starve_cnt <= starve_cnt + SW'(1);
    end
  end

  // Integer x0 writes are consumed but never strobed; FP f0 is a real register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_write_enable <= 1'b0;
      wb_write_addr   <= '0;
      wb_write_data   <= '0;
      wb_is_fp        <= 1'b0;
    end else if (grant) begin
      wb_write_enable <= !((sel_e.rd == 5'd0) && !sel_e.is_fp);
      wb_write_addr   <= sel_e.rd;
      wb_write_data   <= sel_e.data;
      wb_is_fp        <= sel_e.is_fp;
    end else begin
      wb_write_enable <= 1'b0;
    end
  end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter: cycle table plus reset, push/pop-wrap and idle sequences.
module tb_writeback_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid, alu_ready, alu_is_fp;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        ll_valid, ll_ready, ll_is_fp;
  logic [4:0]  ll_rd;
  logic [31:0] ll_data;
  logic        wb_write_enable, wb_is_fp, wb_busy;
  logic [4:0]  wb_write_addr;
  logic [31:0] wb_write_data;
  logic [2:0]  fifo_count;

  int checks = 0;
  int failures = 0;

  writeback_arbiter #(.FIFO_DEPTH(4), .STARVE_LIMIT(3)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd),
    .alu_data(alu_data), .alu_is_fp(alu_is_fp),
    .ll_valid(ll_valid), .ll_ready(ll_ready), .ll_rd(ll_rd),
    .ll_data(ll_data), .ll_is_fp(ll_is_fp),
    .wb_write_enable(wb_write_enable), .wb_write_addr(wb_write_addr),
    .wb_write_data(wb_write_data), .wb_is_fp(wb_is_fp),
    .fifo_count(fifo_count), .wb_busy(wb_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        av;  logic [4:0] ard; logic [31:0] adat; logic afp;
    logic        lv;  logic [4:0] lrd; logic [31:0] ldat; logic lfp;
    logic        e_ar; logic e_lr;
    logic        e_we; logic [4:0] e_addr; logic [31:0] e_data; logic e_fp;
    logic [2:0]  e_cnt;
  } vec_t;

  vec_t vt [20];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] adat, input logic afp,
                       input logic lv, input logic [4:0] lrd, input logic [31:0] ldat, input logic lfp);
    alu_valid = av; alu_rd = ard; alu_data = adat; alu_is_fp = afp;
    ll_valid = lv;  ll_rd = lrd;  ll_data = ldat;  ll_is_fp = lfp;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
  endtask

  // Called at posedge+1: check readies mid-cycle, then registered outputs after the edge.
  task automatic step(input vec_t v, input string nm);
    drive(v.av, v.ard, v.adat, v.afp, v.lv, v.lrd, v.ldat, v.lfp);
    @(negedge clk);
    chk({nm, "_alu_ready"}, 32'(alu_ready), 32'(v.e_ar));
    chk({nm, "_ll_ready"},  32'(ll_ready),  32'(v.e_lr));
    @(posedge clk); #1;
    chk({nm, "_we"},    32'(wb_write_enable), 32'(v.e_we));
    chk({nm, "_count"}, 32'(fifo_count),      32'(v.e_cnt));
    chk({nm, "_busy"},  32'(wb_busy),         32'((v.e_cnt != 0) || v.e_we));
    if (v.e_we) begin
      chk({nm, "_addr"}, 32'(wb_write_addr), 32'(v.e_addr));
      chk({nm, "_data"}, wb_write_data,      v.e_data);
      chk({nm, "_fp"},   32'(wb_is_fp),      32'(v.e_fp));
    end
  endtask

  localparam logic [31:0] A = 32'hA000_0000;
  localparam logic [31:0] L = 32'hB000_0000;

  initial begin
    vec_t v;
    // ALU basics and x0 / f0 handling
    vt[0]  = '{1,5,32'hDEADBEEF,0, 0,0,0,0, 1,1, 1,5,32'hDEADBEEF,0, 0};
    vt[1]  = '{1,0,32'h11111111,0, 0,0,0,0, 1,1, 0,0,0,0, 0};
    vt[2]  = '{1,0,32'h22222222,1, 0,0,0,0, 1,1, 1,0,32'h22222222,1, 0};
    vt[3]  = '{0,0,0,0,            0,0,0,0, 1,1, 0,0,0,0, 0};
    // fill FIFO under constant ALU pressure; forced grant every 4th cycle
    vt[4]  = '{1,1,A+1,0,  1,10,L+0,0, 1,1, 1,1,A+1,0, 1};
    vt[5]  = '{1,2,A+2,0,  1,11,L+1,1, 1,1, 1,2,A+2,0, 2};
    vt[6]  = '{1,3,A+3,0,  1,12,L+2,0, 1,1, 1,3,A+3,0, 3};
    vt[7]  = '{1,4,A+4,1,  1,13,L+3,0, 1,1, 1,4,A+4,1, 4};
    vt[8]  = '{1,6,A+6,0,  1,14,L+4,0, 0,0, 1,10,L+0,0, 3};
    vt[9]  = '{1,6,A+6,0,  0,0,0,0,    1,1, 1,6,A+6,0, 3};
    vt[10] = '{1,7,A+7,0,  0,0,0,0,    1,1, 1,7,A+7,0, 3};
    vt[11] = '{1,8,A+8,0,  0,0,0,0,    1,1, 1,8,A+8,0, 3};
    vt[12] = '{1,9,A+9,0,  0,0,0,0,    0,1, 1,11,L+1,1, 2};
    vt[13] = '{1,9,A+9,0,  0,0,0,0,    1,1, 1,9,A+9,0, 2};
    vt[14] = '{1,15,A+15,0, 0,0,0,0,   1,1, 1,15,A+15,0, 2};
    vt[15] = '{1,16,A+16,0, 0,0,0,0,   1,1, 1,16,A+16,0, 2};
    vt[16] = '{1,17,A+17,0, 0,0,0,0,   0,1, 1,12,L+2,0, 1};
    vt[17] = '{1,17,A+17,0, 0,0,0,0,   1,1, 1,17,A+17,0, 1};
    vt[18] = '{0,0,0,0,     0,0,0,0,   1,1, 1,13,L+3,0, 0};
    vt[19] = '{0,0,0,0,     0,0,0,0,   1,1, 0,0,0,0, 0};

    idle();
    reset = 1'b1;
    #12;
    chk("rst_we", 32'(wb_write_enable), 0);
    chk("rst_addr", 32'(wb_write_addr), 0);
    chk("rst_data", wb_write_data, 0);
    chk("rst_count", 32'(fifo_count), 0);
    chk("rst_ll_ready", 32'(ll_ready), 1);
    chk("rst_alu_ready", 32'(alu_ready), 1);
    chk("rst_busy", 32'(wb_busy), 0);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 20; i++) step(vt[i], $sformatf("v%0d", i));

    // push and pop together at count 2, across pointer wrap
    v = '{1,30,A+30,0, 1,20,32'hC0DE0000,0, 1,1, 1,30,A+30,0, 1};
    step(v, "pp_pre0");
    v = '{1,31,A+31,0, 1,21,32'hC0DE0001,1, 1,1, 1,31,A+31,0, 2};
    step(v, "pp_pre1");
    for (int k = 0; k < 8; k++) begin
      v = '{0,0,0,0, 1,5'(22+k),32'hC0DE0000+32'(k+2),1'(k),
            1,1, 1,5'(20+k),32'hC0DE0000+32'(k),1'(k), 2};
      step(v, $sformatf("pp%0d", k));
    end
    v = '{0,0,0,0, 0,0,0,0, 1,1, 1,28,32'hC0DE0008,0, 1};
    step(v, "pp_drain0");
    v = '{0,0,0,0, 0,0,0,0, 1,1, 1,29,32'hC0DE0009,1, 0};
    step(v, "pp_drain1");

    // ALU idle: push, grant next cycle, write after that, busy falls a cycle later
    v = '{0,0,0,0, 1,7,32'h0BADF00D,0, 1,1, 0,0,0,0, 1};
    step(v, "idle_push");
    v = '{0,0,0,0, 0,0,0,0, 1,1, 1,7,32'h0BADF00D,0, 0};
    step(v, "idle_wr");
    v = '{0,0,0,0, 0,0,0,0, 1,1, 0,0,0,0, 0};
    step(v, "idle_done");

    // reset mid-stream with 3 buffered entries
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 5'(1+k), A+32'(k), 1'b0, 1'b1, 5'(8+k), L+32'(k), 1'b0);
      @(posedge clk); #1;
    end
    chk("mid_count_pre", 32'(fifo_count), 3);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_we", 32'(wb_write_enable), 0);
    chk("mid_rst_addr", 32'(wb_write_addr), 0);
    chk("mid_rst_data", wb_write_data, 0);
    chk("mid_rst_fp", 32'(wb_is_fp), 0);
    chk("mid_rst_count", 32'(fifo_count), 0);
    chk("mid_rst_ll_ready", 32'(ll_ready), 1);
    chk("mid_rst_alu_ready", 32'(alu_ready), 1);
    chk("mid_rst_busy", 32'(wb_busy), 0);
    idle();
    @(negedge clk); reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk($sformatf("post_rst%0d_we", k), 32'(wb_write_enable), 0);
      chk($sformatf("post_rst%0d_count", k), 32'(fifo_count), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
